// File: rtl/free_list.sv
// Circular free list of physical register indices for rename. It allocates up to SS
// registers per cycle, reclaims committed previous mappings, and rewinds on flush.
module free_list #(
  parameter  int SS            = 2,
  parameter  int TABLE_ENTRIES = 64,
  parameter  int ARCH_REGS     = 32,
  localparam int PW            = $clog2(TABLE_ENTRIES),
  localparam int D             = TABLE_ENTRIES - ARCH_REGS,
  localparam int CW            = $clog2(D) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SS-1:0]    alloc_req,
  output logic             alloc_grant,
  output logic [SS*PW-1:0] alloc_preg,
  input  logic [SS-1:0]    commit_valid,
  input  logic [SS*PW-1:0] commit_free_preg,
  input  logic             flush,
  output logic [CW-1:0]    free_count
);

  localparam int IW = CW - 1;

  logic [PW-1:0] mem_q [D];
  logic [PW-1:0] mem_d [D];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] rhead_q, rhead_d;
  logic [CW-1:0] n_req, n_commit;
  logic [CW-1:0] a_ptr, c_ptr;

  always_comb begin
    n_req       = '0;
    n_commit    = '0;
    alloc_preg  = '0;
    a_ptr       = '0;
    c_ptr       = '0;
    mem_d       = mem_q;
    free_count  = tail_q - head_q;

    // Each slot looks up head plus the number of lower-numbered requesting slots.
    for (int unsigned i = 0; i < SS; i++) begin
      a_ptr = head_q + n_req;
      alloc_preg[i*PW +: PW] = mem_q[a_ptr[IW-1:0]];
      if (alloc_req[i]) n_req = n_req + CW'(1);
    end

    for (int unsigned i = 0; i < SS; i++) begin
      c_ptr = tail_q + n_commit;
      if (commit_valid[i]) begin
        mem_d[c_ptr[IW-1:0]] = commit_free_preg[i*PW +: PW];
        n_commit = n_commit + CW'(1);
      end
    end

    alloc_grant = (free_count >= n_req) && !flush;
    tail_d      = tail_q + n_commit;
    rhead_d     = rhead_q + n_commit;
    if (flush)            head_d = rhead_d;
    else if (alloc_grant) head_d = head_q + n_req;
    else                  head_d = head_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= CW'(D);
      for (int unsigned k = 0; k < D; k++) mem_q[k] <= PW'(ARCH_REGS + k);
    end else begin
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      mem_q   <= mem_d;
    end
  end

  // Protocol checks: never return x0's mapping, never overfill the list.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SS; i++)
        if (commit_valid[i])
          assert (commit_free_preg[i*PW +: PW] != '0)
            else $error("free_list: commit of physical register 0 on slot %0d", i);
      assert (32'(free_count) + 32'(n_commit) <= 32'(D))
        else $error("free_list: commit overflows the free list");
    end
  end

endmodule
